// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one imem request at a time,
// buffers a response under decode stall and drops stale responses after redirect.
`timescale 1ns/1ps
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic [31:0] o_instr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic        hold_valid;
    logic        out_free;

    assign out_free       = !o_valid || !stall;
    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC;
            req_pc     <= RESET_PC;
            o_valid    <= 1'b0;
            o_pc       <= '0;
            o_pc4      <= '0;
            o_instr    <= NOP_INSTR;
            hold_pc    <= '0;
            hold_instr <= NOP_INSTR;
            hold_valid <= 1'b0;
        end else begin
            // Decode consumed the bundle; later writes this cycle override.
            if (o_valid && !stall) begin
                o_valid <= 1'b0;
                o_instr <= NOP_INSTR;
            end
            if (redirect) begin
                fetch_pc   <= {redirect_pc[31:2], 2'b00};
                o_valid    <= 1'b0;
                o_instr    <= NOP_INSTR;
                hold_valid <= 1'b0;
                unique case (state)
                    S_REQ:
                        state <= imem_req_ready ? S_DROP : S_REQ;
                    S_WAIT, S_DROP:
                        state <= imem_rsp_valid ? S_REQ : S_DROP;
                    default:
                        state <= S_REQ;
                endcase
            end else begin
                unique case (state)
                    S_IDLE: state <= S_REQ;
                    S_REQ: begin
                        if (imem_req_ready) begin
                            req_pc   <= fetch_pc;
                            fetch_pc <= fetch_pc + 32'd4;
                            state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rsp_valid && out_free) begin
                            o_valid <= 1'b1;
                            o_pc    <= req_pc;
                            o_pc4   <= req_pc + 32'd4;
                            o_instr <= imem_rsp_data;
                            state   <= S_REQ;
                        end else if (imem_rsp_valid) begin
                            hold_pc    <= req_pc;
                            hold_instr <= imem_rsp_data;
                            hold_valid <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            o_valid    <= hold_valid;
                            o_pc       <= hold_pc;
                            o_pc4      <= hold_pc + 32'd4;
                            o_instr    <= hold_valid ? hold_instr
                                                     : NOP_INSTR;
                            hold_valid <= 1'b0;
                            state      <= S_REQ;
                        end
                    end
                    S_DROP: begin
                        if (imem_rsp_valid) state <= S_REQ;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
